// File: rtl/instruction_decode.sv
// instruction_decode -- RV32I decode stage between the IF/ID and ID/EX registers.
//
// Decodes the fetched instruction, builds the sign-extended immediate and the
// execute-stage controls, reads the 32x32 register file (with write-back
// write-through), detects load-use hazards and registers the result into ID/EX.
//
// Ports
//   clk, reset_n          clock; synchronous active-low reset
//   if_instruction_i      instruction from fetch (32'h0 = fetch-flush NOP)
//   if_pc_i               PC of if_instruction_i
//   flush_id_i            squash the instruction in decode (bubble into ID/EX)
//   wb_we_i/rd_i/data_i   register-file write-back port
//   stall_o               combinational load-use stall towards fetch
//   PIP_*                 ID/EX pipeline register outputs
module instruction_decode (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] if_instruction_i,
    input  logic [31:0] if_pc_i,
    input  logic        flush_id_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        stall_o,
    output logic [31:0] PIP_pc_o,
    output logic [31:0] PIP_rs1_data_o,
    output logic [31:0] PIP_rs2_data_o,
    output logic [31:0] PIP_imm_o,
    output logic [4:0]  PIP_rs1_o,
    output logic [4:0]  PIP_rs2_o,
    output logic [4:0]  PIP_rd_o,
    output logic [2:0]  PIP_funct3_o,
    output logic [3:0]  PIP_alu_op_o,
    output logic [1:0]  PIP_op_a_sel_o,
    output logic        PIP_alu_src_imm_o,
    output logic        PIP_mem_read_o,
    output logic        PIP_mem_write_o,
    output logic        PIP_reg_write_o,
    output logic        PIP_branch_o,
    output logic        PIP_jump_o,
    output logic        PIP_illegal_o
);

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111
    } opcode_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'b00,
        OPA_PC   = 2'b01,
        OPA_ZERO = 2'b10
    } op_a_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic [1:0]  op_a_sel;
        logic        alu_src_imm;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } idex_t;

    // ------------------------------------------------------------------
    // Register file. Entry 0 exists only to keep indexing simple; it is
    // never written and never read (x0 reads are forced to zero).
    // ------------------------------------------------------------------
    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs <= '{default: '0};
        end else if (wb_we_i && (wb_rd_i != '0)) begin
            regs[wb_rd_i] <= wb_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Field extraction and immediates
    // ------------------------------------------------------------------
    opcode_e     opcode;
    logic [4:0]  f_rd, f_rs1, f_rs2;
    logic [2:0]  f_funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode   = opcode_e'(if_instruction_i[6:0]);
    assign f_rd     = if_instruction_i[11:7];
    assign f_funct3 = if_instruction_i[14:12];
    assign f_rs1    = if_instruction_i[19:15];
    assign f_rs2    = if_instruction_i[24:20];

    assign imm_i = {{20{if_instruction_i[31]}}, if_instruction_i[31:20]};
    assign imm_s = {{20{if_instruction_i[31]}}, if_instruction_i[31:25], if_instruction_i[11:7]};
    assign imm_b = {{19{if_instruction_i[31]}}, if_instruction_i[31], if_instruction_i[7],
                    if_instruction_i[30:25], if_instruction_i[11:8], 1'b0};
    assign imm_u = {if_instruction_i[31:12], 12'h000};
    assign imm_j = {{11{if_instruction_i[31]}}, if_instruction_i[31], if_instruction_i[19:12],
                    if_instruction_i[20], if_instruction_i[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Control decode. Unused register indices are forced to 0 so that the
    // hazard compare and the operand reads only see real dependencies.
    // ------------------------------------------------------------------
    logic  use_rs1, use_rs2, use_rd;
    idex_t dec;

    always_comb begin
        use_rs1         = 1'b0;
        use_rs2         = 1'b0;
        use_rd          = 1'b0;
        dec             = '0;
        dec.pc          = if_pc_i;
        dec.funct3      = f_funct3;
        dec.op_a_sel    = OPA_RS1;

        case (opcode)
            OPC_OP: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                use_rd        = 1'b1;
                dec.alu_op    = {if_instruction_i[30], f_funct3};
                dec.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                use_rs1         = 1'b1;
                use_rd          = 1'b1;
                // Only SRAI carries funct7[5] into the ALU op; for the other
                // immediate forms bit 30 is immediate data.
                dec.alu_op      = (f_funct3 == 3'b101 && if_instruction_i[30]) ? 4'b1101
                                                                               : {1'b0, f_funct3};
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_i;
                dec.reg_write   = 1'b1;
            end
            OPC_LOAD: begin
                use_rs1         = 1'b1;
                use_rd          = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_i;
                dec.mem_read    = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_STORE: begin
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_s;
                dec.mem_write   = 1'b1;
            end
            OPC_BRANCH: begin
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec.imm    = imm_b;
                dec.branch = 1'b1;
            end
            OPC_JAL: begin
                use_rd          = 1'b1;
                dec.op_a_sel    = OPA_PC;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_j;
                dec.jump        = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_JALR: begin
                use_rs1         = 1'b1;
                use_rd          = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_i;
                dec.jump        = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_LUI: begin
                use_rd          = 1'b1;
                dec.op_a_sel    = OPA_ZERO;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_u;
                dec.reg_write   = 1'b1;
            end
            OPC_AUIPC: begin
                use_rd          = 1'b1;
                dec.op_a_sel    = OPA_PC;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_u;
                dec.reg_write   = 1'b1;
            end
            OPC_MISC_MEM: begin
                // FENCE behaves as a NOP in this in-order pipeline.
            end
            default: begin
                // The all-zero fetch NOP lands here but is not an illegal op.
                dec.illegal = (if_instruction_i != '0);
            end
        endcase

        dec.rs1 = use_rs1 ? f_rs1 : '0;
        dec.rs2 = use_rs2 ? f_rs2 : '0;
        dec.rd  = use_rd  ? f_rd  : '0;

        // Operand reads with write-back forwarding.
        if (dec.rs1 != '0) begin
            dec.rs1_data = (wb_we_i && wb_rd_i == dec.rs1) ? wb_data_i : regs[dec.rs1];
        end
        if (dec.rs2 != '0) begin
            dec.rs2_data = (wb_we_i && wb_rd_i == dec.rs2) ? wb_data_i : regs[dec.rs2];
        end
    end

    // ------------------------------------------------------------------
    // Load-use hazard and ID/EX register
    // ------------------------------------------------------------------
    idex_t idex_q;
    logic  load_bubble;

    // dec.rs1/rs2 are zero when unused, and PIP rd must be nonzero, so an
    // unused operand can never match.
    assign stall_o = idex_q.mem_read && (idex_q.rd != '0) && !flush_id_i &&
                     ((dec.rs1 == idex_q.rd) || (dec.rs2 == idex_q.rd));

    assign load_bubble = stall_o || flush_id_i || (if_instruction_i == '0);

    always_ff @(posedge clk) begin
        if (!reset_n || load_bubble) begin
            idex_q <= '0;
        end else begin
            idex_q <= dec;
        end
    end

    assign PIP_pc_o          = idex_q.pc;
    assign PIP_rs1_data_o    = idex_q.rs1_data;
    assign PIP_rs2_data_o    = idex_q.rs2_data;
    assign PIP_imm_o         = idex_q.imm;
    assign PIP_rs1_o         = idex_q.rs1;
    assign PIP_rs2_o         = idex_q.rs2;
    assign PIP_rd_o          = idex_q.rd;
    assign PIP_funct3_o      = idex_q.funct3;
    assign PIP_alu_op_o      = idex_q.alu_op;
    assign PIP_op_a_sel_o    = idex_q.op_a_sel;
    assign PIP_alu_src_imm_o = idex_q.alu_src_imm;
    assign PIP_mem_read_o    = idex_q.mem_read;
    assign PIP_mem_write_o   = idex_q.mem_write;
    assign PIP_reg_write_o   = idex_q.reg_write;
    assign PIP_branch_o      = idex_q.branch;
    assign PIP_jump_o        = idex_q.jump;
    assign PIP_illegal_o     = idex_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode -- randomized scoreboard bench for instruction_decode.
//
// A reference model decodes each issued instruction from the RV32I field
// rules and tracks the architectural register file; expected ID/EX contents
// and stall are queued per cycle and popped by an independent monitor.
module tb_instruction_decode;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic [1:0]  op_a_sel;
        logic        alu_src_imm;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } idex_t;

    typedef struct packed {
        logic  chk;
        logic  stall;
        idex_t idex;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] if_instruction_i;
    logic [31:0] if_pc_i;
    logic        flush_id_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        stall_o;
    logic [31:0] PIP_pc_o, PIP_rs1_data_o, PIP_rs2_data_o, PIP_imm_o;
    logic [4:0]  PIP_rs1_o, PIP_rs2_o, PIP_rd_o;
    logic [2:0]  PIP_funct3_o;
    logic [3:0]  PIP_alu_op_o;
    logic [1:0]  PIP_op_a_sel_o;
    logic        PIP_alu_src_imm_o, PIP_mem_read_o, PIP_mem_write_o;
    logic        PIP_reg_write_o, PIP_branch_o, PIP_jump_o, PIP_illegal_o;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .if_instruction_i  (if_instruction_i),
        .if_pc_i           (if_pc_i),
        .flush_id_i        (flush_id_i),
        .wb_we_i           (wb_we_i),
        .wb_rd_i           (wb_rd_i),
        .wb_data_i         (wb_data_i),
        .stall_o           (stall_o),
        .PIP_pc_o          (PIP_pc_o),
        .PIP_rs1_data_o    (PIP_rs1_data_o),
        .PIP_rs2_data_o    (PIP_rs2_data_o),
        .PIP_imm_o         (PIP_imm_o),
        .PIP_rs1_o         (PIP_rs1_o),
        .PIP_rs2_o         (PIP_rs2_o),
        .PIP_rd_o          (PIP_rd_o),
        .PIP_funct3_o      (PIP_funct3_o),
        .PIP_alu_op_o      (PIP_alu_op_o),
        .PIP_op_a_sel_o    (PIP_op_a_sel_o),
        .PIP_alu_src_imm_o (PIP_alu_src_imm_o),
        .PIP_mem_read_o    (PIP_mem_read_o),
        .PIP_mem_write_o   (PIP_mem_write_o),
        .PIP_reg_write_o   (PIP_reg_write_o),
        .PIP_branch_o      (PIP_branch_o),
        .PIP_jump_o        (PIP_jump_o),
        .PIP_illegal_o     (PIP_illegal_o)
    );

    idex_t act;
    assign act = {PIP_pc_o, PIP_rs1_data_o, PIP_rs2_data_o, PIP_imm_o, PIP_rs1_o, PIP_rs2_o,
                  PIP_rd_o, PIP_funct3_o, PIP_alu_op_o, PIP_op_a_sel_o, PIP_alu_src_imm_o,
                  PIP_mem_read_o, PIP_mem_write_o, PIP_reg_write_o, PIP_branch_o, PIP_jump_o,
                  PIP_illegal_o};

    // ---------------- reference model state ----------------
    exp_t        sb[$];
    logic [31:0] mregs [32];
    idex_t       midex = '0;
    logic        m_stall = 1'b0;
    logic        m_live = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                               input logic [4:0] wrd, input logic [31:0] wdata);
        if (idx == 5'd0) return 32'h0;
        if (we && wrd == idx) return wdata;
        return mregs[idx];
    endfunction

    function automatic idex_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic we, input logic [4:0] wrd,
                                           input logic [31:0] wdata);
        idex_t       r;
        int          s;
        logic [31:0] ii, is_, ib, iu, ij;
        logic        u1, u2, urd;
        r   = '0;
        s   = $signed(ins);
        ii  = $unsigned(s >>> 20);
        is_ = $unsigned((s >>> 25) <<< 5) | ((ins >> 7) & 32'h1f);
        ib  = $unsigned((s >>> 31) <<< 12) | (((ins >> 7) & 32'h1) << 11)
            | (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1);
        iu  = ins & 32'hFFFFF000;
        ij  = $unsigned((s >>> 31) <<< 20) | (((ins >> 12) & 32'hff) << 12)
            | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3ff) << 1);
        u1 = 1'b0; u2 = 1'b0; urd = 1'b0;
        r.pc     = pc;
        r.funct3 = ins[14:12];
        case (ins[6:0])
            7'b0110011: begin u1 = 1; u2 = 1; urd = 1; r.alu_op = {ins[30], ins[14:12]}; r.reg_write = 1; end
            7'b0010011: begin
                u1 = 1; urd = 1; r.alu_src_imm = 1; r.imm = ii; r.reg_write = 1;
                r.alu_op = (ins[14:12] == 3'd5 && ins[30]) ? 4'hD : {1'b0, ins[14:12]};
            end
            7'b0000011: begin u1 = 1; urd = 1; r.alu_src_imm = 1; r.imm = ii; r.mem_read = 1; r.reg_write = 1; end
            7'b0100011: begin u1 = 1; u2 = 1; r.alu_src_imm = 1; r.imm = is_; r.mem_write = 1; end
            7'b1100011: begin u1 = 1; u2 = 1; r.imm = ib; r.branch = 1; end
            7'b1101111: begin urd = 1; r.op_a_sel = 2'b01; r.alu_src_imm = 1; r.imm = ij; r.jump = 1; r.reg_write = 1; end
            7'b1100111: begin u1 = 1; urd = 1; r.alu_src_imm = 1; r.imm = ii; r.jump = 1; r.reg_write = 1; end
            7'b0110111: begin urd = 1; r.op_a_sel = 2'b10; r.alu_src_imm = 1; r.imm = iu; r.reg_write = 1; end
            7'b0010111: begin urd = 1; r.op_a_sel = 2'b01; r.alu_src_imm = 1; r.imm = iu; r.reg_write = 1; end
            7'b0001111: begin end
            default:    r.illegal = (ins != 32'h0);
        endcase
        r.rs1      = u1  ? ins[19:15] : 5'd0;
        r.rs2      = u2  ? ins[24:20] : 5'd0;
        r.rd       = urd ? ins[11:7]  : 5'd0;
        r.rs1_data = model_read(r.rs1, we, wrd, wdata);
        r.rs2_data = model_read(r.rs2, we, wrd, wdata);
        return r;
    endfunction

    // One cycle of stimulus: drive inputs just after the edge, queue the
    // expectation for this cycle, then advance the model across the next edge.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                        input logic we, input logic [4:0] rd, input logic [31:0] data,
                        input logic rst);
        idex_t d;
        exp_t  e;
        @(posedge clk);
        #1;
        if_instruction_i = ins;
        if_pc_i          = pc;
        flush_id_i       = fl;
        wb_we_i          = we;
        wb_rd_i          = rd;
        wb_data_i        = data;
        reset_n          = rst;
        d = model_decode(ins, pc, we, rd, data);
        m_stall = midex.mem_read && midex.rd != 5'd0 && !fl &&
                  (d.rs1 == midex.rd || d.rs2 == midex.rd);
        e.chk   = m_live;
        e.stall = m_stall;
        e.idex  = midex;
        sb.push_back(e);
        if (!rst) begin
            midex = '0;
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
            m_live = 1'b1;
        end else begin
            midex = (m_stall || fl || ins == 32'h0) ? idex_t'(0) : d;
            if (we && rd != 5'd0) mregs[rd] = data;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] r;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom);
        r   = $urandom;
        case ($urandom_range(0, 13))
            0:  return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'b0110011};
            1:  return {r[31:20], rs1, f3, rd, 7'b0010011};
            2:  return {r[31:20], rs1, f3, rd, 7'b0000011};
            3:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'b0100011};
            4:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'b1100011};
            5:  return {r[31:12], rd, 7'b1101111};
            6:  return {r[31:20], rs1, 3'b000, rd, 7'b1100111};
            7:  return {r[31:12], rd, 7'b0110111};
            8:  return {r[31:12], rd, 7'b0010111};
            9:  return {r[31:7], 7'b0001111};
            10: return 32'h00000073;
            11: return 32'h0;
            12: return r;
            default: return {12'h000, rs1, 3'b010, rd, 7'b0000011};
        endcase
    endfunction

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.chk) begin
                n_checks++;
                if (act !== mon_e.idex) begin
                    n_fail++;
                    $display("FAIL idex @%0t: actual %h required %h", $time, act, mon_e.idex);
                end
                n_checks++;
                if (stall_o !== mon_e.stall) begin
                    n_fail++;
                    $display("FAIL stall @%0t: actual %b required %b", $time, stall_o, mon_e.stall);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] ins, pc;
    logic        fl, we, rst;
    logic [4:0]  wrd;

    initial begin
        reset_n = 1'b0; if_instruction_i = '0; if_pc_i = '0; flush_id_i = 1'b0;
        wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;

        step(32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 0);
        step(32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 0);
        // addi x1,x0,5
        step(32'h00500093, 32'h100, 0, 0, 5'd0, 32'h0, 1);
        // add x3,x2,x2 with write-through of x2, then from storage
        step(32'h002101B3, 32'h104, 0, 1, 5'd2, 32'hDEADBEEF, 1);
        step(32'h002101B3, 32'h108, 0, 0, 5'd0, 32'h0, 1);
        // add x7,x0,x0 while writing x0
        step(32'h000003B3, 32'h10C, 0, 1, 5'd0, 32'h1234, 1);
        step(32'h000003B3, 32'h110, 0, 0, 5'd0, 32'h0, 1);
        // load-use: lw x5,0(x1); add x6,x5,x5 (held one cycle)
        step(32'h0000A283, 32'h200, 0, 0, 5'd0, 32'h0, 1);
        step(32'h00528333, 32'h204, 0, 0, 5'd0, 32'h0, 1);
        step(32'h00528333, 32'h204, 0, 0, 5'd0, 32'h0, 1);
        step(32'h0, 32'h208, 0, 0, 5'd0, 32'h0, 1);
        // flush in the hazard cycle
        step(32'h0000A283, 32'h300, 0, 0, 5'd0, 32'h0, 1);
        step(32'h00528333, 32'h304, 1, 0, 5'd0, 32'h0, 1);
        step(32'h0, 32'h308, 0, 0, 5'd0, 32'h0, 1);
        // beq, ecall (illegal), fetch NOP
        step(32'hFE000CE3, 32'h400, 0, 0, 5'd0, 32'h0, 1);
        step(32'h00000073, 32'h404, 0, 0, 5'd0, 32'h0, 1);
        step(32'h0, 32'h408, 0, 0, 5'd0, 32'h0, 1);
        // reset arriving in the stall cycle
        step(32'h0000A283, 32'h500, 0, 0, 5'd0, 32'h0, 1);
        step(32'h00528333, 32'h504, 0, 0, 5'd0, 32'h0, 0);
        step(32'h00528333, 32'h504, 0, 0, 5'd0, 32'h0, 1);
        step(32'h0, 32'h508, 0, 0, 5'd0, 32'h0, 1);

        ins = 32'h0; pc = 32'h1000;
        for (int n = 0; n < 3000; n++) begin
            if (!m_stall) begin
                ins = rand_instr();
                pc  = pc + 32'd4;
            end
            fl  = ($urandom_range(0, 9) == 0);
            we  = ($urandom_range(0, 2) != 0);
            wrd = 5'($urandom_range(0, 7));
            rst = ($urandom_range(0, 299) != 0);
            step(ins, pc, fl, we, wrd, $urandom, rst);
        end
        step(32'h0, pc, 0, 0, 5'd0, 32'h0, 1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: actual %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
